// File: rtl/mem_mode_ctrl_pkg.sv
// Shared types and constants for the three-mode storage sequencer
// (shift register, 4x4 RAM, 4x4 ROM).
package mem_mode_pkg;

   localparam int NBITS_DATA_C = 4;
   localparam int NWORDS_C     = 4;
   localparam int ADDR_W_C     = 2;
   localparam int STATE_W_C    = 3;

   // Mode field. Both 01 and 11 select the RAM.
   typedef enum logic [1:0] {
      MODE_SHIFT   = 2'b00,
      MODE_RAM     = 2'b01,
      MODE_ROM     = 2'b10,
      MODE_RAM_ALT = 2'b11
   } mode_t;

   // Sequencer states. The encoding is exported on state_dbg.
   typedef enum logic [STATE_W_C-1:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      MEM_REQ = 3'd2,
      MEM_RSP = 3'd3,
      SCAN    = 3'd4
   } state_t;

   // ROM image, word 0 in the least significant nibble.
   localparam logic [NWORDS_C*NBITS_DATA_C-1:0] ROM_INIT = {4'hA, 4'h5, 4'hC, 4'h3};

   // ROM lookup by word address.
   function automatic logic [NBITS_DATA_C-1:0] rom_word(input logic [ADDR_W_C-1:0] a);
      return ROM_INIT[a*NBITS_DATA_C +: NBITS_DATA_C];
   endfunction

   // A write is the only operation that is illegal, and only in ROM mode.
   function automatic logic cmd_is_legal(input mode_t m, input logic wr);
      return !((m == MODE_ROM) && wr);
   endfunction

endpackage

// File: rtl/mem_mode_ctrl_if.sv
// Command and result bundle between the board wiring and mem_mode_ctrl.
// master: side that drives switches/strobe; slave: the controller.
interface mem_mode_ctrl_if #(
   parameter int NBITS_DATA = 4,
   parameter int NWORDS     = 4
);
   localparam int AW = $clog2(NWORDS);

   logic [1:0]            mode;
   logic                  go;
   logic                  load_par;
   logic                  wr_en;
   logic [AW-1:0]         addr;
   logic [NBITS_DATA-1:0] din;
   logic                  sin;
   logic [NBITS_DATA-1:0] dout;
   logic                  sout;
   logic                  busy;
   logic                  drop;
   logic                  err;
   logic [2:0]            state_dbg;

   modport master (
      output mode, go, load_par, wr_en, addr, din, sin,
      input  dout, sout, busy, drop, err, state_dbg
   );

   modport slave (
      input  mode, go, load_par, wr_en, addr, din, sin,
      output dout, sout, busy, drop, err, state_dbg
   );

endinterface

// File: rtl/mem_mode_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// The edge history is held at HIST_RST until the synchronizer has been
// refilled after reset, so an input that is already high when reset
// releases is not mistaken for a fresh edge.
module sync_edge #(
   parameter logic HIST_RST = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   logic       sync1_r;
   logic       sync2_r;
   logic       hist_r;
   logic [1:0] prime_r;

   // Synchronizer chain, priming shift and edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         hist_r  <= HIST_RST;
         prime_r <= 2'b00;
      end else begin
         sync1_r <= async_in;
         sync2_r <= sync1_r;
         prime_r <= {prime_r[0], 1'b1};
         hist_r  <= prime_r[1] ? sync2_r : HIST_RST;
      end
   end

   assign pulse = sync2_r & ~hist_r;

endmodule

// File: rtl/mem_mode_ctrl.sv
// Sequencer for the shift-register / RAM / ROM storage exercise.
// Accepts a synchronized command edge in IDLE, latches the operands and
// runs one multi-cycle operation, leaving a registered result on dout.
// Optional build macro: MEM_MODE_CTRL_SCAN_EN (ROM read scans all words).
module mem_mode_ctrl
   import mem_mode_pkg::*;
#(
   parameter int NBITS_DATA = 4,
   parameter int NWORDS     = 4
) (
   input  logic            clk_2,
   input  logic            reset_n,
   mem_mode_ctrl_if.slave  bus
);

   localparam int AW = $clog2(NWORDS);

   // Command edge
   logic go_pulse_s;

   // FSM
   state_t state_r;
   state_t state_nxt;

   // Latched command
   mode_t                 cmd_mode_r;
   logic                  cmd_load_par_r;
   logic                  cmd_wr_en_r;
   logic [AW-1:0]         cmd_addr_r;
   logic [NBITS_DATA-1:0] cmd_din_r;
   logic                  cmd_sin_r;
   logic                  accept_s;

   // Storage
   logic [NBITS_DATA-1:0] sr_r;
   logic [NBITS_DATA-1:0] sr_nxt;
   logic [NBITS_DATA-1:0] ram_r [NWORDS];
   logic                  ram_we_s;
   logic [AW-1:0]         rd_addr_r;
   logic [AW-1:0]         rd_addr_nxt;
   logic [NBITS_DATA-1:0] rd_data_s;
   logic                  is_rom_s;

   // Registered outputs
   logic [NBITS_DATA-1:0] dout_r;
   logic [NBITS_DATA-1:0] dout_nxt;
   logic                  sout_r;
   logic                  sout_nxt;
   logic                  busy_r;
   logic                  drop_r;
   logic                  err_r;
   logic                  err_nxt;

`ifdef MEM_MODE_CTRL_SCAN_EN
   logic [AW-1:0]         scan_cnt_r;
   logic [AW-1:0]         scan_cnt_nxt;
`endif

   sync_edge #(
      .HIST_RST (1'b1)
   ) u_sync_edge (
      .clk      (clk_2),
      .rst_n    (reset_n),
      .async_in (bus.go),
      .pulse    (go_pulse_s)
   );

   // Synchronous-read data: address was registered in MEM_REQ.
   always_comb begin
      is_rom_s  = (cmd_mode_r == MODE_ROM);
      rd_data_s = is_rom_s ? rom_word(rd_addr_r) : ram_r[rd_addr_r];
   end

   // Next-state and datapath next values.
   always_comb begin
      state_nxt   = state_r;
      accept_s    = 1'b0;
      sr_nxt      = sr_r;
      dout_nxt    = dout_r;
      sout_nxt    = sout_r;
      err_nxt     = err_r;
      ram_we_s    = 1'b0;
      rd_addr_nxt = rd_addr_r;
`ifdef MEM_MODE_CTRL_SCAN_EN
      scan_cnt_nxt = scan_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (go_pulse_s) begin
               accept_s = 1'b1;
               if (mode_t'(bus.mode) == MODE_SHIFT) begin
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = MEM_REQ;
               end
               if (cmd_is_legal(mode_t'(bus.mode), bus.wr_en)) begin
                  err_nxt = 1'b0;
               end else begin
                  err_nxt = err_r;
               end
`ifdef MEM_MODE_CTRL_SCAN_EN
               scan_cnt_nxt = {AW{1'b0}};
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (cmd_load_par_r) begin
               sr_nxt = cmd_din_r;
            end else begin
               sr_nxt   = {sr_r[NBITS_DATA-2:0], cmd_sin_r};
               sout_nxt = sr_r[NBITS_DATA-1];
            end
            dout_nxt  = sr_nxt;
            state_nxt = IDLE;
         end
         MEM_REQ: begin
            rd_addr_nxt = cmd_addr_r;
            if (is_rom_s) begin
               // ROM never writes; a write request degrades to a read.
               if (cmd_wr_en_r) begin
                  err_nxt = 1'b1;
               end else begin
                  err_nxt = err_r;
               end
            end else begin
               ram_we_s = cmd_wr_en_r;
            end
`ifdef MEM_MODE_CTRL_SCAN_EN
            if (is_rom_s) begin
               state_nxt = SCAN;
            end else begin
               state_nxt = MEM_RSP;
            end
`else
            state_nxt = MEM_RSP;
`endif
         end
         MEM_RSP: begin
            if (!is_rom_s && cmd_wr_en_r) begin
               dout_nxt = cmd_din_r;
            end else begin
               dout_nxt = rd_data_s;
            end
            state_nxt = IDLE;
         end
         SCAN: begin
`ifdef MEM_MODE_CTRL_SCAN_EN
            dout_nxt     = rom_word(scan_cnt_r);
            scan_cnt_nxt = scan_cnt_r + 2'd1;
            if (scan_cnt_r == 2'd3) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = SCAN;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Operand capture on command accept.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         cmd_mode_r     <= MODE_SHIFT;
         cmd_load_par_r <= 1'b0;
         cmd_wr_en_r    <= 1'b0;
         cmd_addr_r     <= {AW{1'b0}};
         cmd_din_r      <= {NBITS_DATA{1'b0}};
         cmd_sin_r      <= 1'b0;
      end else if (accept_s) begin
         cmd_mode_r     <= mode_t'(bus.mode);
         cmd_load_par_r <= bus.load_par;
         cmd_wr_en_r    <= bus.wr_en;
         cmd_addr_r     <= bus.addr;
         cmd_din_r      <= bus.din;
         cmd_sin_r      <= bus.sin;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         sr_r      <= {NBITS_DATA{1'b0}};
         rd_addr_r <= {AW{1'b0}};
         dout_r    <= {NBITS_DATA{1'b0}};
         sout_r    <= 1'b0;
         busy_r    <= 1'b0;
         drop_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         sr_r      <= sr_nxt;
         rd_addr_r <= rd_addr_nxt;
         dout_r    <= dout_nxt;
         sout_r    <= sout_nxt;
         busy_r    <= (state_nxt != IDLE);
         drop_r    <= go_pulse_s && (state_r != IDLE);
         err_r     <= err_nxt;
      end
   end

   // RAM array; cleared by reset so an interrupted write leaves no trace.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NWORDS; i++) begin
            ram_r[i] <= {NBITS_DATA{1'b0}};
         end
      end else if (ram_we_s) begin
         ram_r[cmd_addr_r] <= cmd_din_r;
      end
   end

`ifdef MEM_MODE_CTRL_SCAN_EN
   // ROM scan word counter.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt_r <= {AW{1'b0}};
      end else begin
         scan_cnt_r <= scan_cnt_nxt;
      end
   end
`endif

   assign bus.dout      = dout_r;
   assign bus.sout      = sout_r;
   assign bus.busy      = busy_r;
   assign bus.drop      = drop_r;
   assign bus.err       = err_r;
   assign bus.state_dbg = state_r;

endmodule

// File: tb/tb_mem_mode_ctrl.sv
// Directed bench for mem_mode_ctrl. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
module tb_mem_mode_ctrl;

   logic clk_2   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk_2 = ~clk_2;

   mem_mode_ctrl_if #(.NBITS_DATA(4), .NWORDS(4)) bus_if ();

   mem_mode_ctrl #(
      .NBITS_DATA (4),
      .NWORDS     (4)
   ) dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] prev_dout;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_2);
      #1;
   endtask

   task automatic set_cmd(input logic [1:0] m, input logic lp, input logic wr,
                          input logic [1:0] a, input logic [3:0] d, input logic s);
      bus_if.mode     = m;
      bus_if.load_par = lp;
      bus_if.wr_en    = wr;
      bus_if.addr     = a;
      bus_if.din      = d;
      bus_if.sin      = s;
   endtask

   // One command with full timing checks; go rises now (cycle 0), so
   // go_pulse is in cycle 2 and the FSM leaves IDLE in cycle 3.
   task automatic op(input string tag, input logic is_mem,
                     input logic [3:0] exp_d, input logic exp_s);
      bus_if.go = 1'b1;
      step(2);
      chk({tag, " busy pre"}, 8'(bus_if.busy), 8'd0);
      step(1);
      chk({tag, " busy N+1"}, 8'(bus_if.busy), 8'd1);
      chk({tag, " state N+1"}, 8'(bus_if.state_dbg), is_mem ? 8'd2 : 8'd1);
      // operands are latched; scramble the inputs
      bus_if.mode     = ~bus_if.mode;
      bus_if.load_par = ~bus_if.load_par;
      bus_if.wr_en    = ~bus_if.wr_en;
      bus_if.addr     = ~bus_if.addr;
      bus_if.din      = ~bus_if.din;
      bus_if.sin      = ~bus_if.sin;
      if (!is_mem) begin
         step(1);
         chk({tag, " busy N+2"}, 8'(bus_if.busy), 8'd0);
         chk({tag, " dout"}, 8'(bus_if.dout), 8'(exp_d));
         chk({tag, " sout"}, 8'(bus_if.sout), 8'(exp_s));
      end else begin
         step(1);
         chk({tag, " busy N+2"}, 8'(bus_if.busy), 8'd1);
         chk({tag, " state N+2"}, 8'(bus_if.state_dbg), 8'd3);
         chk({tag, " dout N+2 old"}, 8'(bus_if.dout), 8'(prev_dout));
         step(1);
         chk({tag, " busy N+3"}, 8'(bus_if.busy), 8'd0);
         chk({tag, " dout"}, 8'(bus_if.dout), 8'(exp_d));
      end
      prev_dout = exp_d;
      bus_if.go = 1'b0;
      step(4);
   endtask

   initial begin
      bus_if.go = 1'b1;
      set_cmd(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
      prev_dout = 4'h0;

      // Reset with go held high
      step(3);
      chk("rst dout", 8'(bus_if.dout), 8'd0);
      chk("rst sout", 8'(bus_if.sout), 8'd0);
      chk("rst busy", 8'(bus_if.busy), 8'd0);
      chk("rst drop", 8'(bus_if.drop), 8'd0);
      chk("rst err", 8'(bus_if.err), 8'd0);
      chk("rst state", 8'(bus_if.state_dbg), 8'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("held go busy", 8'(bus_if.busy), 8'd0);
      end
      chk("held go dout", 8'(bus_if.dout), 8'd0);
      bus_if.go = 1'b0;
      step(4);

      // Shift register: parallel load then serial shift
      set_cmd(2'b00, 1'b1, 1'b0, 2'd0, 4'h9, 1'b0);
      op("load9", 1'b0, 4'h9, 1'b0);
      set_cmd(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
      op("shift1", 1'b0, 4'h3, 1'b1);

      // Command edge landing in the cycle SHIFT returns to IDLE
      set_cmd(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
      bus_if.go = 1'b1;
      step(1);
      bus_if.go = 1'b0;
      step(1);
      bus_if.go = 1'b1;
      step(1);
      chk("b2b busy 1st", 8'(bus_if.busy), 8'd1);
      bus_if.sin = 1'b1;
      step(1);
      chk("b2b busy gap", 8'(bus_if.busy), 8'd0);
      chk("b2b dout 1st", 8'(bus_if.dout), 8'h6);
      chk("b2b sout 1st", 8'(bus_if.sout), 8'd0);
      step(1);
      chk("b2b busy 2nd", 8'(bus_if.busy), 8'd1);
      chk("b2b drop", 8'(bus_if.drop), 8'd0);
      step(1);
      chk("b2b dout 2nd", 8'(bus_if.dout), 8'hD);
      chk("b2b sout 2nd", 8'(bus_if.sout), 8'd0);
      chk("b2b drop end", 8'(bus_if.drop), 8'd0);
      bus_if.go = 1'b0;
      step(4);

      // Wrap-around: 1000 shifted with sin 0
      set_cmd(2'b00, 1'b1, 1'b0, 2'd0, 4'h8, 1'b0);
      op("load8", 1'b0, 4'h8, 1'b0);
      set_cmd(2'b00, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
      op("wrap", 1'b0, 4'h0, 1'b1);

      // RAM write, read back (alias mode 11), read untouched word
      set_cmd(2'b01, 1'b0, 1'b1, 2'd2, 4'h6, 1'b0);
      op("wr6", 1'b1, 4'h6, 1'b0);
      set_cmd(2'b11, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0);
      op("rd2", 1'b1, 4'h6, 1'b0);
      set_cmd(2'b01, 1'b0, 1'b0, 2'd1, 4'hF, 1'b0);
      op("rd1", 1'b1, 4'h0, 1'b0);

      // ROM write attempt: read instead, error flag set
      set_cmd(2'b10, 1'b0, 1'b1, 2'd1, 4'hF, 1'b0);
      op("romwr", 1'b1, 4'hC, 1'b0);
      chk("romwr err", 8'(bus_if.err), 8'd1);
      set_cmd(2'b01, 1'b0, 1'b0, 2'd1, 4'h0, 1'b0);
      op("rd1b", 1'b1, 4'h0, 1'b0);
      chk("err clear", 8'(bus_if.err), 8'd0);

      // Second edge while busy is dropped
      set_cmd(2'b01, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0);
      bus_if.go = 1'b1;
      step(1);
      bus_if.go = 1'b0;
      step(1);
      bus_if.go = 1'b1;
      step(1);
      chk("drop state req", 8'(bus_if.state_dbg), 8'd2);
      step(1);
      chk("drop pre", 8'(bus_if.drop), 8'd0);
      step(1);
      chk("drop pulse", 8'(bus_if.drop), 8'd1);
      chk("drop dout", 8'(bus_if.dout), 8'h6);
      chk("drop busy", 8'(bus_if.busy), 8'd0);
      step(1);
      chk("drop once", 8'(bus_if.drop), 8'd0);
      chk("drop busy2", 8'(bus_if.busy), 8'd0);
      step(1);
      chk("drop idle", 8'(bus_if.state_dbg), 8'd0);
      bus_if.go = 1'b0;
      step(4);

      // Reset during MEM_REQ of a RAM write
      set_cmd(2'b01, 1'b0, 1'b1, 2'd3, 4'hF, 1'b0);
      bus_if.go = 1'b1;
      step(3);
      chk("mid state", 8'(bus_if.state_dbg), 8'd2);
      chk("mid sout pre", 8'(bus_if.sout), 8'd1);
      reset_n   = 1'b0;
      bus_if.go = 1'b0;
      #1;
      chk("mid rst dout", 8'(bus_if.dout), 8'd0);
      chk("mid rst sout", 8'(bus_if.sout), 8'd0);
      chk("mid rst busy", 8'(bus_if.busy), 8'd0);
      chk("mid rst state", 8'(bus_if.state_dbg), 8'd0);
      step(2);
      reset_n = 1'b1;
      step(4);
      prev_dout = 4'h0;
      set_cmd(2'b01, 1'b0, 1'b0, 2'd3, 4'h0, 1'b0);
      op("rd3 lost", 1'b1, 4'h0, 1'b0);
      set_cmd(2'b01, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0);
      op("rd2 cleared", 1'b1, 4'h0, 1'b0);

`ifdef MEM_MODE_CTRL_SCAN_EN
      // ROM scan: 3, C, 5, A on consecutive cycles
      set_cmd(2'b10, 1'b0, 1'b0, 2'd1, 4'h0, 1'b0);
      bus_if.go = 1'b1;
      step(3);
      chk("scan busy N+1", 8'(bus_if.busy), 8'd1);
      step(1);
      chk("scan state", 8'(bus_if.state_dbg), 8'd4);
      chk("scan dout old", 8'(bus_if.dout), 8'h0);
      step(1);
      chk("scan w0", 8'(bus_if.dout), 8'h3);
      step(1);
      chk("scan w1", 8'(bus_if.dout), 8'hC);
      step(1);
      chk("scan w2", 8'(bus_if.dout), 8'h5);
      chk("scan busy N+5", 8'(bus_if.busy), 8'd1);
      step(1);
      chk("scan w3", 8'(bus_if.dout), 8'hA);
      chk("scan busy N+6", 8'(bus_if.busy), 8'd0);
      chk("scan idle", 8'(bus_if.state_dbg), 8'd0);
      bus_if.go = 1'b0;
      step(4);
`else
      // Single-word ROM reads
      set_cmd(2'b10, 1'b0, 1'b0, 2'd3, 4'h0, 1'b0);
      op("rom3", 1'b1, 4'hA, 1'b0);
      set_cmd(2'b10, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
      op("rom0", 1'b1, 4'h3, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
